minrv32_uart_tx: RTL

Memory-mapped console transmitter on the minrv32 data bus. It replaces the bench-only character sink at 0x1000_0000 with a synthesizable peripheral. CPU byte writes are pushed into a small FIFO and serialized as 8N1 UART frames on `tx`. The CPU polls the status register and is stalled with `mem_ready` low when the FIFO is full.

---
 rtl/minrv32_uart_pkg.sv | 25 ++
 rtl/minrv32_sync_fifo.sv | 57 +++++
 rtl/minrv32_uart_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/minrv32_uart_pkg.sv
// minrv32 console UART transmitter: shared register map, status bit layout
// and transmitter FSM state encoding.
package minrv32_uart_pkg;

  // Register offsets within the 8-byte window
  localparam logic [2:0] TXDATA_OFS = 3'd0;
  localparam logic [2:0] STATUS_OFS = 3'd4;

  // STATUS register bit positions
  localparam int unsigned FULL_BIT   = 0;
  localparam int unsigned EMPTY_BIT  = 1;
  localparam int unsigned BUSY_BIT   = 2;
  localparam int unsigned PARITY_BIT = 3;
  localparam int unsigned COUNT_LSB  = 8;

  // Serializer states; PARITY is only entered when the parity option is built in
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/minrv32_sync_fifo.sv
// Single-clock FIFO with registered occupancy count. Push is ignored when
// full and pop is ignored when empty; full/empty derive from the count
// register, so both reflect the state before the current edge.
module minrv32_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/minrv32_uart_tx.sv
// Memory-mapped 8N1 console transmitter for the minrv32 data bus.
// TXDATA (offset 0) queues a byte, STATUS (offset 4) reports FIFO/FSM state.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit between DATA and STOP.
module minrv32_uart_tx
  import minrv32_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic [3:0]  mem_rmask,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic        PARITY_EN   = 1'b1;
`else
  localparam logic        PARITY_EN   = 1'b0;
`endif

  logic            sel;
  logic            is_write;
  logic            is_read;
  logic            at_txdata;
  logic            at_status;
  logic            push_req;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CW-1:0]   fifo_count;
  logic [31:0]     status;

  tx_state_e       state_q;
  tx_state_e       state_d;
  logic [15:0]     baud_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shreg_q;
  logic            baud_tick;
  logic            tx_d;
  logic            tx_q;
  logic            irq_q;
  logic            unused_wdata;

  assign unused_wdata = ^mem_wdata[31:8];

  // Bus decode
  assign sel       = mem_valid && (mem_addr[31:3] == BASE_ADDR[31:3]);
  assign is_write  = |mem_wstrb;
  assign is_read   = |mem_rmask;
  assign at_txdata = (mem_addr[2:0] == TXDATA_OFS);
  assign at_status = (mem_addr[2:0] == STATUS_OFS);
  assign push_req  = sel && is_write && at_txdata && mem_wstrb[0];

  // A TXDATA push holds the bus while full; everything else completes at once
  assign mem_ready = sel && !(push_req && fifo_full);
  assign fifo_push = push_req && !fifo_full;

  minrv32_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .wdata  (mem_wdata[7:0]),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // STATUS register image
  always_comb begin
    status                   = '0;
    status[FULL_BIT]         = fifo_full;
    status[EMPTY_BIT]        = fifo_empty;
    status[BUSY_BIT]         = (state_q != IDLE);
    status[PARITY_BIT]       = PARITY_EN;
    status[COUNT_LSB +: 8]   = 8'(fifo_count);
  end

  // Read data mux: only STATUS reads return non-zero data
  always_comb begin
    mem_rdata = '0;
    if (sel && is_read && !is_write && at_status) mem_rdata = status;
  end

  assign baud_tick = (baud_q == '0);

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state and FIFO pop request
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (baud_tick) state_d = DATA;
      end
      DATA: begin
        if (baud_tick && (bit_idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: begin
        if (baud_tick) state_d = STOP;
      end
      STOP: begin
        if (baud_tick) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = START;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output: serial line level for the current state
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_q[bit_idx_q];
      PARITY:  tx_d = ^shreg_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // Baud counter, bit index and shift register; a pop reloads all three
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else if (fifo_pop) begin
      baud_q    <= BAUD_RELOAD;
      bit_idx_q <= '0;
      shreg_q   <= fifo_rdata;
    end else if (state_q != IDLE) begin
      if (baud_tick) begin
        baud_q <= BAUD_RELOAD;
        if (state_q == DATA) bit_idx_q <= bit_idx_q + 1'b1;
      end else begin
        baud_q <= baud_q - 1'b1;
      end
    end
  end

  // Registered line driver and drained interrupt
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_q  <= 1'b1;
      irq_q <= 1'b1;
    end else begin
      tx_q  <= tx_d;
      irq_q <= fifo_empty && (state_q == IDLE);
    end
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule
